// File: rtl/character_ctl_if.sv
// Character controller bus: per-frame control inputs from the game side and
// the registered sprite position/state returned to the draw stage.
interface character_ctl_if;
    logic        module_en;
    logic        frame_tick;
    logic        jump_btn;
    logic        left_btn;
    logic        right_btn;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        airborne;
    logic [1:0]  state;

    modport master (
        output module_en, frame_tick, jump_btn, left_btn, right_btn,
        input  xpos, ypos, airborne, state
    );

    modport slave (
        input  module_en, frame_tick, jump_btn, left_btn, right_btn,
        output xpos, ypos, airborne, state
    );
endinterface

// File: rtl/character_ctl.sv
// Character sprite motion controller: samples buttons once per frame and runs
// a jump/fall state machine with integer gravity and clamped horizontal moves.
module character_ctl #(
    parameter int X_INIT   = 375,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 650,
    parameter int Y_GROUND = 400,
    parameter int Y_MIN    = 0,
    parameter int H_STEP   = 4,
    parameter int JUMP_V   = 20,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 16
) (
    input  logic          clk,
    input  logic          rst,
    character_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GROUND  = 2'b01,
        ASCEND  = 2'b10,
        DESCEND = 2'b11
    } state_t;

    // All position math is carried in 12-bit signed so underflow below zero is visible
    localparam logic signed [11:0] X_INIT_S   = signed'(12'(X_INIT));
    localparam logic signed [11:0] X_MIN_S    = signed'(12'(X_MIN));
    localparam logic signed [11:0] X_MAX_S    = signed'(12'(X_MAX));
    localparam logic signed [11:0] Y_GROUND_S = signed'(12'(Y_GROUND));
    localparam logic signed [11:0] Y_MIN_S    = signed'(12'(Y_MIN));
    localparam logic signed [11:0] H_STEP_S   = signed'(12'(H_STEP));
    localparam logic signed [11:0] JUMP_V_S   = signed'(12'(JUMP_V));
    localparam logic [7:0]         JUMP_V8    = 8'(JUMP_V);
    localparam logic [7:0]         GRAV8      = 8'(GRAVITY);
    localparam logic [7:0]         VMAX8      = 8'(V_MAX);

    function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                   input logic signed [11:0] lo,
                                                   input logic signed [11:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Falling speed gains gravity but never exceeds terminal velocity
    function automatic logic [7:0] vel_up(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, GRAV8};
        if (s > {1'b0, VMAX8}) return VMAX8;
        return s[7:0];
    endfunction

    // Rising speed loses gravity and bottoms out at zero
    function automatic logic [7:0] vel_down(input logic [7:0] v);
        if (v <= GRAV8) return 8'd0;
        return v - GRAV8;
    endfunction

    state_t      state_q, state_n;
    logic [10:0] x_q, x_n;
    logic [10:0] y_q, y_n;
    logic [7:0]  vel_q, vel_n;
    logic        pend_q, pend_n;
    logic        jump_prev_q;
    logic        air_q, air_n;

    logic               jump_edge;
    logic               jump_req;
    logic signed [11:0] x_s, y_s, vel_s;
    logic signed [11:0] x_move;
    logic signed [11:0] y_tmp;
    logic [7:0]         v_new;

    // Registered state, positions, speed, pending jump and button history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= X_INIT_S[10:0];
            y_q         <= Y_GROUND_S[10:0];
            vel_q       <= 8'd0;
            pend_q      <= 1'b0;
            jump_prev_q <= 1'b0;
            air_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            x_q         <= x_n;
            y_q         <= y_n;
            vel_q       <= vel_n;
            pend_q      <= pend_n;
            jump_prev_q <= bus.jump_btn;
            air_q       <= air_n;
        end
    end

    // Next-state, motion and jump-request logic
    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        vel_n   = vel_q;
        v_new   = 8'd0;
        y_tmp   = 12'sd0;

        x_s   = signed'({1'b0, x_q});
        y_s   = signed'({1'b0, y_q});
        vel_s = signed'({4'b0, vel_q});

        // Edges while in the air are dropped so a held or mashed button cannot queue a jump
        jump_edge = bus.jump_btn & ~jump_prev_q;
        jump_req  = pend_q | (jump_edge & ~(state_q == ASCEND || state_q == DESCEND));
        pend_n    = bus.frame_tick ? 1'b0 : jump_req;

        x_move = x_s;
        if (bus.left_btn && !bus.right_btn)
            x_move = clamp12(x_s - H_STEP_S, X_MIN_S, X_MAX_S);
        else if (bus.right_btn && !bus.left_btn)
            x_move = clamp12(x_s + H_STEP_S, X_MIN_S, X_MAX_S);

        unique case (state_q)
            IDLE: state_n = GROUND;
            GROUND: begin
                if (bus.frame_tick) begin
                    x_n = x_move[10:0];
                    if (jump_req) begin
                        y_tmp   = clamp12(Y_GROUND_S - JUMP_V_S, Y_MIN_S, Y_GROUND_S);
                        y_n     = y_tmp[10:0];
                        vel_n   = JUMP_V8 - GRAV8;
                        state_n = ASCEND;
                    end
                end
            end
            ASCEND: begin
                if (bus.frame_tick) begin
                    x_n   = x_move[10:0];
                    y_tmp = y_s - vel_s;
                    if (y_tmp < Y_MIN_S) begin
                        y_n     = Y_MIN_S[10:0];
                        vel_n   = 8'd0;
                        state_n = DESCEND;
                    end else begin
                        y_n   = y_tmp[10:0];
                        vel_n = vel_down(vel_q);
                        if (vel_q <= GRAV8) state_n = DESCEND;
                    end
                end
            end
            DESCEND: begin
                if (bus.frame_tick) begin
                    x_n   = x_move[10:0];
                    v_new = vel_up(vel_q);
                    y_tmp = y_s + signed'({4'b0, v_new});
                    if (y_tmp >= Y_GROUND_S) begin
                        y_n     = Y_GROUND_S[10:0];
                        vel_n   = 8'd0;
                        state_n = GROUND;
                    end else begin
                        y_n   = y_tmp[10:0];
                        vel_n = v_new;
                    end
                end
            end
        endcase

        // Disabling the game parks the character regardless of any tick
        if (!bus.module_en) begin
            state_n = IDLE;
            x_n     = X_INIT_S[10:0];
            y_n     = Y_GROUND_S[10:0];
            vel_n   = 8'd0;
            pend_n  = 1'b0;
        end

        air_n = (state_n == ASCEND) || (state_n == DESCEND);
    end

    assign bus.xpos     = x_q;
    assign bus.ypos     = y_q;
    assign bus.airborne = air_q;
    assign bus.state    = state_q;

endmodule
